bus_responder: RTL and testbench

- Synchronous memory and IO responder for the 6502 core bus: the target end of the core's addr/rw/data_o → data_i/ready interface.
- Fast regions:
  - Internal RAM, 1-cycle read.
  - Open-bus fallback, 1-cycle read.
- IO page: bridged to an external req/ack port with wait-state insertion (ready low), a 1-deep posted-write buffer and a timeout watchdog.
- Sits between core and system peripherals in the top level.

---
 rtl/bus_responder.sv | 172 +++++++++++++++++
 tb/tb_bus_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// bus_responder: target end of the 6502 core bus. RAM and open bus answer in one cycle;
// the IO page is bridged to a req/ack port with a posted write buffer and a watchdog.
module bus_responder #(
  parameter int unsigned RAM_AW      = 11,
  parameter logic [7:0]  IO_PAGE     = 8'h40,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic [7:0]  data_o,
  output logic [7:0]  data_i,
  output logic        ready,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  input  logic        err_clr,
  output logic        err_timeout,
  output logic        err_ovf
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RD_REQ = 2'd1;
  localparam logic [1:0] WR_REQ = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] mem [2**RAM_AW];

  logic [1:0] fsm_q, fsm_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic [7:0] pend_addr_q, pend_addr_d;
  logic [7:0] data_i_q, data_i_d;
  logic       ready_q, ready_d;
  logic       io_req_q, io_req_d;
  logic       io_we_q, io_we_d;
  logic [7:0] io_addr_q, io_addr_d;
  logic [7:0] io_wdata_q, io_wdata_d;
  logic       err_timeout_q, err_timeout_d;
  logic       err_ovf_q, err_ovf_d;

  logic hit_ram, hit_io, timeout_hit, io_done, set_ovf, ram_we;

  assign hit_ram     = (addr >> RAM_AW) == 16'd0;
  assign hit_io      = !hit_ram && (addr[15:8] == IO_PAGE);
  assign timeout_hit = io_req_q && !io_ack && (cnt_q >= TO_LAST);
  assign io_done     = io_req_q && (io_ack || timeout_hit);
  // A stalled access is held by the core; only decode when the last one was answered
  assign ram_we      = !rst && ready_q && hit_ram && !rw;

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    rd_pend_d   = rd_pend_q;
    pend_addr_d = pend_addr_q;
    data_i_d    = data_i_q;
    ready_d     = ready_q;
    io_req_d    = io_req_q;
    io_we_d     = io_we_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    set_ovf     = 1'b0;

    if (io_req_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;

    if (ready_q) begin
      if (hit_ram) begin
        if (rw) data_i_d = mem[addr[RAM_AW-1:0]];
      end else if (hit_io) begin
        if (rw) begin
          ready_d = 1'b0;
          if (fsm_q == WR_REQ) begin
            rd_pend_d   = 1'b1;
            pend_addr_d = addr[7:0];
          end else begin
            fsm_d     = RD_REQ;
            io_req_d  = 1'b1;
            io_we_d   = 1'b0;
            io_addr_d = addr[7:0];
            cnt_d     = 8'd0;
          end
        end else if (fsm_q == WR_REQ) begin
          set_ovf = 1'b1;
        end else begin
          fsm_d      = WR_REQ;
          io_req_d   = 1'b1;
          io_we_d    = 1'b1;
          io_addr_d  = addr[7:0];
          io_wdata_d = data_o;
          cnt_d      = 8'd0;
        end
      end
    end

    // Completion by ack or watchdog; a write that ends releases any read waiting on it
    if (io_done) begin
      case (fsm_q)
        RD_REQ: begin
          fsm_d    = IDLE;
          io_req_d = 1'b0;
          ready_d  = 1'b1;
          data_i_d = io_ack ? io_rdata : 8'hFF;
        end
        WR_REQ: begin
          if (rd_pend_d) begin
            fsm_d     = RD_REQ;
            io_req_d  = 1'b1;
            io_we_d   = 1'b0;
            io_addr_d = pend_addr_d;
            cnt_d     = 8'd0;
            rd_pend_d = 1'b0;
          end else begin
            fsm_d    = IDLE;
            io_req_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    err_timeout_d = timeout_hit || (err_timeout_q && !err_clr);
    err_ovf_d     = set_ovf || (err_ovf_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q         <= IDLE;
      cnt_q         <= 8'd0;
      rd_pend_q     <= 1'b0;
      pend_addr_q   <= 8'd0;
      data_i_q      <= 8'd0;
      ready_q       <= 1'b1;
      io_req_q      <= 1'b0;
      io_we_q       <= 1'b0;
      io_addr_q     <= 8'd0;
      io_wdata_q    <= 8'd0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      cnt_q         <= cnt_d;
      rd_pend_q     <= rd_pend_d;
      pend_addr_q   <= pend_addr_d;
      data_i_q      <= data_i_d;
      ready_q       <= ready_d;
      io_req_q      <= io_req_d;
      io_we_q       <= io_we_d;
      io_addr_q     <= io_addr_d;
      io_wdata_q    <= io_wdata_d;
      err_timeout_q <= err_timeout_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[addr[RAM_AW-1:0]] <= data_o;
  end

  assign data_i      = data_i_q;
  assign ready       = ready_q;
  assign io_req      = io_req_q;
  assign io_we       = io_we_q;
  assign io_addr     = io_addr_q;
  assign io_wdata    = io_wdata_q;
  assign err_timeout = err_timeout_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized core/IO traffic.
`timescale 1ns/1ps
module tb_bus_responder;
  localparam int TO     = 8;
  localparam int RAM_SZ = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  data_o;
  logic [7:0]  data_i;
  logic        ready;
  logic        io_req;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        io_ack;
  logic        err_clr;
  logic        err_timeout;
  logic        err_ovf;

  bus_responder #(.RAM_AW(11), .IO_PAGE(8'h40), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rw(rw), .data_o(data_o), .data_i(data_i),
    .ready(ready), .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack), .err_clr(err_clr), .err_timeout(err_timeout),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding IO job, an optional read waiting behind it
  logic [7:0] m_mem [RAM_SZ];
  logic [7:0] m_data, m_ioaddr, m_wdata, m_wait_addr;
  logic       m_ready, m_req, m_we, m_eto, m_eovf;
  int         m_age;
  bit         m_wait_rd;

  task automatic start_job(input logic we, input logic [7:0] a, input logic [7:0] d);
    m_req = 1'b1; m_we = we; m_ioaddr = a; m_age = 1;
    if (we) m_wdata = d;
  endtask

  task automatic model_step();
    bit was_req, was_we, acc, fin, to_evt, ovf_evt;
    if (rst) begin
      m_data = 0; m_ready = 1; m_req = 0; m_we = 0; m_ioaddr = 0; m_wdata = 0;
      m_eto = 0; m_eovf = 0; m_age = 0; m_wait_rd = 0;
      return;
    end
    was_req = m_req; was_we = m_we; acc = m_ready;
    fin = 0; to_evt = 0; ovf_evt = 0;
    if (was_req) begin
      if (io_ack) fin = 1;
      else if (m_age >= TO) begin fin = 1; to_evt = 1; end
      else m_age++;
    end
    if (fin) begin
      m_req = 0;
      if (!was_we) begin m_data = to_evt ? 8'hFF : io_rdata; m_ready = 1; end
      if (m_wait_rd) begin m_wait_rd = 0; start_job(1'b0, m_wait_addr, 8'h00); end
    end
    if (acc) begin
      if (addr < RAM_SZ) begin
        if (rw) m_data = m_mem[addr[10:0]];
        else m_mem[addr[10:0]] = data_o;
      end else if (addr[15:8] == 8'h40) begin
        if (!rw) begin
          if (was_req && was_we) ovf_evt = 1;
          else start_job(1'b1, addr[7:0], data_o);
        end else begin
          m_ready = 0;
          if (m_req) begin m_wait_rd = 1; m_wait_addr = addr[7:0]; end
          else start_job(1'b0, addr[7:0], 8'h00);
        end
      end
    end
    m_eto  = to_evt  ? 1'b1 : (err_clr ? 1'b0 : m_eto);
    m_eovf = ovf_evt ? 1'b1 : (err_clr ? 1'b0 : m_eovf);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("data_i",      16'(data_i),      16'(m_data));
      chk("ready",       16'(ready),       16'(m_ready));
      chk("io_req",      16'(io_req),      16'(m_req));
      chk("io_we",       16'(io_we),       16'(m_we));
      chk("io_addr",     16'(io_addr),     16'(m_ioaddr));
      chk("io_wdata",    16'(io_wdata),    16'(m_wdata));
      chk("err_timeout", 16'(err_timeout), 16'(m_eto));
      chk("err_ovf",     16'(err_ovf),     16'(m_eovf));
    end
  end

  // IO peripheral: ack in the ack_at-th cycle of a request (0 = never, -1 = random)
  int         ack_at   = -1;
  bit         fixed_en = 0;
  logic [7:0] fixed_val = 8'h00;
  bit         spur_en  = 0;
  int         p_age    = 0;
  int         p_tgt    = 0;

  initial begin
    io_ack = 1'b0;
    io_rdata = 8'h00;
    forever begin
      @(negedge clk);
      io_ack = 1'b0;
      io_rdata = fixed_en ? fixed_val : 8'($urandom);
      if (io_req === 1'b1) begin
        p_age++;
        if (p_age == 1)
          p_tgt = (ack_at >= 0) ? ack_at :
                  (($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 10)));
        if (p_tgt != 0 && p_age == p_tgt) begin io_ack = 1'b1; p_age = 0; end
      end else begin
        p_age = 0;
        if (spur_en && $urandom_range(0, 7) == 0) io_ack = 1'b1;
      end
    end
  end

  // Core side: a new access is presented only in a cycle with ready=1
  task automatic next_access(input logic [15:0] a, input logic r, input logic [7:0] d);
    int guard = 0;
    while (ready !== 1'b1 && guard < 64) begin @(negedge clk); guard++; end
    chk("stall_bound", 16'(ready), 16'd1);
    addr = a; rw = r; data_o = d;
    @(negedge clk);
  endtask

  task automatic wait_ready(output int stall, output int hi);
    stall = 0; hi = 0;
    while (ready !== 1'b1 && stall < 64) begin
      if (io_req === 1'b1) hi++;
      stall++;
      @(negedge clk);
    end
  endtask

  task automatic filler();
    next_access(16'h9000, 1'b1, 8'h00);
  endtask

  int         st, hi, seen2;
  bit         saw_rd;
  logic [7:0] rd_seen_addr;
  logic [15:0] ra;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addr = 16'h9000; rw = 1'b1; data_o = 8'h00; err_clr = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_data_i", 16'(data_i), 16'h0);
    chk("rst_ready",  16'(ready),  16'h1);
    chk("rst_io_req", 16'(io_req), 16'h0);
    chk("rst_io_we",  16'(io_we),  16'h0);
    chk("rst_io_addr", 16'(io_addr), 16'h0);
    chk("rst_err",    16'({err_timeout, err_ovf}), 16'h0);
    rst = 1'b0;

    next_access(16'h0123, 1'b0, 8'hA5);
    next_access(16'h0123, 1'b1, 8'h00);
    chk("ram_rd_data",  16'(data_i), 16'h00A5);
    chk("ram_rd_ready", 16'(ready),  16'h1);
    chk("ram_no_req",   16'(io_req), 16'h0);

    ack_at = 4; fixed_en = 1; fixed_val = 8'h3C;
    next_access(16'h4010, 1'b1, 8'h00);
    wait_ready(st, hi);
    chk("io_rd_stall", 16'(st), 16'd4);
    chk("io_rd_data",  16'(data_i), 16'h003C);
    chk("io_rd_addr",  16'(io_addr), 16'h0010);
    chk("io_rd_we",    16'(io_we), 16'h0);

    ack_at = 5; fixed_en = 0;
    next_access(16'h4001, 1'b0, 8'h11);
    chk("wr1_req",   16'(io_req), 16'h1);
    chk("wr1_wdata", 16'(io_wdata), 16'h0011);
    chk("wr1_ready", 16'(ready), 16'h1);
    next_access(16'h4002, 1'b0, 8'h22);
    chk("wr2_ovf",   16'(err_ovf), 16'h1);
    chk("wr2_wdata", 16'(io_wdata), 16'h0011);
    seen2 = 0;
    repeat (8) begin
      if (io_req === 1'b1 && io_addr == 8'h02) seen2++;
      filler();
    end
    chk("wr2_never_issued", 16'(seen2), 16'd0);
    chk("wr_done_req", 16'(io_req), 16'h0);
    err_clr = 1'b1; filler(); err_clr = 1'b0;
    chk("ovf_cleared", 16'(err_ovf), 16'h0);

    ack_at = 3;
    next_access(16'h4005, 1'b0, 8'h55);
    next_access(16'h4020, 1'b1, 8'h00);
    chk("wr_rd_stall", 16'(ready), 16'h0);
    saw_rd = 0; rd_seen_addr = 8'h00; st = 0;
    while (ready !== 1'b1 && st < 64) begin
      if (io_req === 1'b1 && io_we === 1'b0 && !saw_rd) begin saw_rd = 1; rd_seen_addr = io_addr; end
      st++;
      @(negedge clk);
    end
    chk("wr_rd_issued", 16'(saw_rd), 16'h1);
    chk("wr_rd_addr",   16'(rd_seen_addr), 16'h0020);
    chk("wr_rd_noerr",  16'({err_timeout, err_ovf}), 16'h0);

    ack_at = 0;
    next_access(16'h4030, 1'b1, 8'h00);
    wait_ready(st, hi);
    chk("to_req_cycles", 16'(hi), 16'd8);
    chk("to_data",       16'(data_i), 16'h00FF);
    chk("to_flag",       16'(err_timeout), 16'h1);
    chk("to_req_low",    16'(io_req), 16'h0);
    err_clr = 1'b1; filler(); err_clr = 1'b0;
    chk("to_cleared", 16'(err_timeout), 16'h0);
    ack_at = 8; fixed_en = 1; fixed_val = 8'h5A;
    next_access(16'h4030, 1'b1, 8'h00);
    wait_ready(st, hi);
    chk("ack8_req_cycles", 16'(hi), 16'd8);
    chk("ack8_data",       16'(data_i), 16'h005A);
    chk("ack8_noerr",      16'(err_timeout), 16'h0);

    ack_at = 0; fixed_en = 0;
    next_access(16'h4040, 1'b1, 8'h00);
    chk("rstmid_req_before", 16'(io_req), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_req",   16'(io_req), 16'h0);
    chk("rstmid_ready", 16'(ready), 16'h1);
    chk("rstmid_data",  16'(data_i), 16'h0);
    rst = 1'b0;
    next_access(16'h9000, 1'b1, 8'h00);
    chk("openbus_after_rst", 16'(data_i), 16'h0);

    for (int i = 0; i < RAM_SZ; i++) next_access(16'(i), 1'b0, 8'($urandom));

    ack_at = -1; spur_en = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0;
      end
      err_clr = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: ra = 16'($urandom_range(0, 15));
        1: ra = 16'($urandom_range(0, RAM_SZ - 1));
        2: ra = {8'h40, 8'($urandom)};
        default: begin
          ra = 16'($urandom_range(16'h0800, 16'hFFFF));
          if (ra[15:8] == 8'h40) ra = ra ^ 16'h8000;
        end
      endcase
      next_access(ra, 1'($urandom), 8'($urandom));
    end
    err_clr = 1'b0; spur_en = 0; ack_at = 1;
    repeat (12) filler();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
